// File: rtl/shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_register_pkg
// Purpose : Shared constants and helpers for the shift_register persistence
//           qualifier: legal range of N and the run-counter width rule.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package shift_register_pkg;

  // Legal range for the hold-time parameter N.
  localparam int unsigned N_MIN = 1;
  localparam int unsigned N_MAX = 65535;

  // Width of a counter that must represent every value 0..n inclusive.
  // Out-of-range n is clamped to 1 bit so elaboration reaches the range check
  // in the module rather than failing on a zero-width vector first.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n < N_MIN) begin
      return 1;
    end
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
// Module  : shift_register
// Purpose : Persistence (hold-time) qualifier. `on` is high only while the
//           last N rising-edge samples of `in` were all 1. Equivalent to the
//           AND of all taps of an N-stage shift register fed by `in`, but
//           built as a saturating run counter so large N stays cheap.
// Ports   : clk   - system clock, all state changes on the rising edge
//           reset - synchronous active-high reset, overrides `in`
//           in    - condition being qualified
//           on    - registered qualified output
// Revision: 1.0  initial release
// ============================================================================
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned N = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic on
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] C_N   = CW'(N);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  // Reject illegal N at elaboration time.
  if ((N < N_MIN) || (N > N_MAX)) begin : g_n_range_check
    $error("shift_register: N=%0d is outside the legal range 1..65535", N);
  end

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          on_q;
  logic          on_d;

  // Run counter: any low sample restarts the run; a high sample extends it,
  // holding at N so a long-held input never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!in) begin
      cnt_d = '0;
    end else if (cnt_q != C_N) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  // Output is registered from the next-state count, which keeps it
  // cycle-identical to decoding (cnt_q == N) while presenting a clean flop
  // output with no path from `in` to `on` inside the same cycle.
  always_comb begin
    on_d = (cnt_d == C_N);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      on_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
    end
  end

  assign on = on_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_register.sv
`default_nettype none
// ============================================================================
// Module  : tb_shift_register
// Purpose : Self-checking bench for shift_register. Instances: N=4, N=1, and
//           a default-N (256) instance cascaded into an N=3840 instance.
//           Expected `on` comes from a window model: a queue of the samples
//           of `in` since the last reset, where `on` is true when the newest
//           N entries exist and are all 1.
// Revision: 1.0  initial release
// ============================================================================
module tb_shift_register;

  logic clk = 1'b0;
  logic reset;
  logic in4;
  logic in1;
  logic in_a;
  logic on4;
  logic on1;
  logic on_a;
  logic on_b;

  int vectors     = 0;
  int miscompares = 0;

  bit hist4[$];
  bit hist1[$];

  always #5 clk = ~clk;

  shift_register #(.N(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .in    (in4),
    .on    (on4)
  );

  shift_register #(.N(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .in    (in1),
    .on    (on1)
  );

  // Default N (256) feeding a 60 s-style N=3840 stage.
  shift_register dut_a (
    .clk   (clk),
    .reset (reset),
    .in    (in_a),
    .on    (on_a)
  );

  shift_register #(.N(3840)) dut_b (
    .clk   (clk),
    .reset (reset),
    .in    (on_a),
    .on    (on_b)
  );

  // True when the newest n samples exist and are all high.
  function automatic logic window_all_ones(input bit h[$], input int n);
    if (h.size() < n) return 1'b0;
    for (int i = h.size() - n; i < h.size(); i++) begin
      if (!h[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: drive at negedge, update the model at the edge, check
  // both small instances 1 time unit after the edge.
  task automatic step(input logic r, input logic a4, input logic a1);
    @(negedge clk);
    reset = r;
    in4   = a4;
    in1   = a1;
    @(posedge clk);
    if (r) begin
      hist4.delete();
      hist1.delete();
    end else begin
      hist4.push_back(a4);
      hist1.push_back(a1);
      if (hist4.size() > 8) void'(hist4.pop_front());
      if (hist1.size() > 8) void'(hist1.pop_front());
    end
    #1;
    check("on_n4", on4, window_all_ones(hist4, 4));
    check("on_n1", on1, window_all_ones(hist1, 1));
  endtask

  initial begin
    reset = 1'b1;
    in4   = 1'b1;
    in1   = 1'b1;
    in_a  = 1'b0;

    // Reset held 2 edges with in high: on stays low.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("reset_on_n4", on4, 1'b0);
    check("reset_on_a", on_a, 1'b0);
    check("reset_on_b", on_b, 1'b0);

    // Qualify/hold: 10 high edges, on from edge 4 onward.
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, k[0]);
      check("qualify_n4", on4, (k >= 4) ? 1'b1 : 1'b0);
      check("n1_delay", on1, k[0]);
    end

    // Deassert: one low sample drops on immediately.
    step(1'b0, 1'b0, 1'b0);
    check("deassert_n4", on4, 1'b0);
    // Re-qualify needs 4 fresh highs; also exercises 3-high drop-out.
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("requal_low_n4", on4, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    check("dropout_n4", on4, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("dropout_requal_n4", on4, (k == 4) ? 1'b1 : 1'b0);
    end

    // Reset while on, with in still high.
    step(1'b1, 1'b1, 1'b1);
    check("reset_while_on_n4", on4, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 1'b1);
      check("post_reset_n4", on4, (k >= 4) ? 1'b1 : 1'b0);
    end

    // Randomised: in4 biased high so runs reach N, occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)));
    end

    // Cascade from reset with in_a held high: 256 then 256+3840 edges.
    @(negedge clk);
    in_a = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    check("cascade_reset_a", on_a, 1'b0);
    check("cascade_reset_b", on_b, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4100; k++) begin
      @(posedge clk);
      #1;
      check("cascade_a", on_a, (k >= 256) ? 1'b1 : 1'b0);
      check("cascade_b", on_b, (k >= 4096) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
